mem_port_arbiter: RTL

Shares one single-ported 16-bit memory between the CPU's instruction-fetch port and data (load/store) port. Each port makes a request; the arbiter picks a winner, runs the memory access for a parameterised number of wait states, returns read data with a one-cycle ack pulse, and drives a stall to the pipeline while any request is outstanding. It sits between the CPU (i_addr/i_datain, d_addr/d_dataout/d_we/d_datain) and the shared RAM.

---
 rtl/mem_port_arbiter_if.sv | 39 +++
 rtl/mem_port_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles the signals of the shared-memory arbiter: the CPU fetch port
// (i_*), the CPU data port (d_*), the shared RAM port (m_*) and the
// pipeline stall.
//   slave  : arbiter side. It receives requests and memory read data. It
//            drives rdata/ack, the m_* controls and stall.
//   master : CPU/RAM side. It is the mirror image of slave.
// Parameters: ADDR_W (address width), DATA_W (data width).
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ack;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;
    logic              m_en;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;
    logic              stall;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        output i_rdata, i_ack, d_rdata, d_ack, m_en, m_we, m_addr, m_wdata, stall
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        input  i_rdata, i_ack, d_rdata, d_ack, m_en, m_we, m_addr, m_wdata, stall
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported memory between the CPU instruction-fetch port
// and the data (load/store) port.
//
// Requests are sampled only in IDLE. The winner's address, write enable
// and write data are latched into the m_* registers. The access then runs
// for WAIT_STATES cycles (ACCESS), and a DONE cycle pulses the winner's
// ack. The data port normally has priority.
//
// Optional feature, selected with the macro ARB_STARVE_GUARD_EN: a starve
// counter grants the fetch port after STARVE_LIMIT consecutive data grants
// made while a fetch was waiting.
//
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : mem_port_arbiter_if.slave, which carries the i_*, d_* and m_*
//           signals and stall
module mem_port_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 16,
    parameter int WAIT_STATES  = 1,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    mem_port_arbiter_if.slave     bus
);
    // A zero wait-state request still needs one enabled memory cycle.
    localparam int WS_EFF = (WAIT_STATES < 1) ? 1 : WAIT_STATES;
    localparam int CNT_W  = (WS_EFF > 1) ? $clog2(WS_EFF) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WS_EFF - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t            state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [1:0]        grant_r;      // bit1 = data port, bit0 = fetch port
    logic              m_en_r;
    logic              m_we_r;
    logic [ADDR_W-1:0] m_addr_r;
    logic [DATA_W-1:0] m_wdata_r;
    logic [DATA_W-1:0] i_rdata_r;
    logic [DATA_W-1:0] d_rdata_r;
    logic              i_ack_r;
    logic              d_ack_r;

    logic              guard_s;      // forces the fetch port to win
    logic              pick_d_s;
    logic              pick_i_s;

`ifdef ARB_STARVE_GUARD_EN
    localparam int STV_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [STV_W-1:0] STV_MAX = STV_W'(STARVE_LIMIT);

    logic [STV_W-1:0] starve_r;

    assign guard_s = bus.i_req & (starve_r == STV_MAX);

    // Starve counter: counts data grants won while a fetch waits.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            starve_r <= {STV_W{1'b0}};
        end else if (state_r == ST_IDLE) begin
            if (!bus.i_req || pick_i_s) begin
                starve_r <= {STV_W{1'b0}};
            end else if (pick_d_s && (starve_r != STV_MAX)) begin
                starve_r <= starve_r + STV_W'(1);
            end else begin
                starve_r <= starve_r;
            end
        end else begin
            starve_r <= starve_r;
        end
    end
`else
    assign guard_s = 1'b0;
`endif

    // Winner selection: data first, unless the starve guard steps in.
    always_comb begin
        pick_d_s = 1'b0;
        pick_i_s = 1'b0;
        if (bus.d_req && !guard_s) begin
            pick_d_s = 1'b1;
        end else if (bus.i_req) begin
            pick_i_s = 1'b1;
        end else begin
            pick_d_s = 1'b0;
            pick_i_s = 1'b0;
        end
    end

    // Access FSM with all memory-side and CPU-side outputs registered.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            grant_r   <= 2'b00;
            m_en_r    <= 1'b0;
            m_we_r    <= 1'b0;
            m_addr_r  <= {ADDR_W{1'b0}};
            m_wdata_r <= {DATA_W{1'b0}};
            i_rdata_r <= {DATA_W{1'b0}};
            d_rdata_r <= {DATA_W{1'b0}};
            i_ack_r   <= 1'b0;
            d_ack_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    i_ack_r <= 1'b0;
                    d_ack_r <= 1'b0;
                    if (pick_d_s || pick_i_s) begin
                        grant_r   <= {pick_d_s, pick_i_s};
                        m_addr_r  <= pick_d_s ? bus.d_addr : bus.i_addr;
                        m_we_r    <= pick_d_s & bus.d_we;
                        m_wdata_r <= pick_d_s ? bus.d_wdata : {DATA_W{1'b0}};
                        m_en_r    <= 1'b1;
                        cnt_r     <= CNT_INIT;
                        state_r   <= ST_ACCESS;
                    end else begin
                        m_en_r  <= 1'b0;
                        m_we_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        // Memory read data is valid in this last enabled cycle.
                        if (!m_we_r) begin
                            if (grant_r[1]) begin
                                d_rdata_r <= bus.m_rdata;
                            end else begin
                                i_rdata_r <= bus.m_rdata;
                            end
                        end else begin
                            d_rdata_r <= d_rdata_r;
                        end
                        i_ack_r <= grant_r[0];
                        d_ack_r <= grant_r[1];
                        m_en_r  <= 1'b0;
                        m_we_r  <= 1'b0;
                        state_r <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    i_ack_r <= 1'b0;
                    d_ack_r <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    m_en_r  <= 1'b0;
                    m_we_r  <= 1'b0;
                    i_ack_r <= 1'b0;
                    d_ack_r <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.m_en    = m_en_r;
    assign bus.m_we    = m_we_r;
    assign bus.m_addr  = m_addr_r;
    assign bus.m_wdata = m_wdata_r;
    assign bus.i_rdata = i_rdata_r;
    assign bus.d_rdata = d_rdata_r;
    assign bus.i_ack   = i_ack_r;
    assign bus.d_ack   = d_ack_r;
    assign bus.stall   = (bus.i_req & ~i_ack_r) | (bus.d_req & ~d_ack_r);
endmodule
